// File: rtl/iq_envelope_if.sv
// I/Q sample in, envelope amplitude out. The envelope block is the slave; the
// sample source and the downstream limiter together form the master side.
interface iq_envelope_if;
  logic               in_valid;
  logic signed [15:0] in_i;
  logic signed [15:0] in_q;
  logic        [15:0] amplitude;
  logic               valid;

  modport master (
    output in_valid, in_i, in_q,
    input  amplitude, valid
  );

  modport slave (
    input  in_valid, in_i, in_q,
    output amplitude, valid
  );
endinterface

// File: rtl/iq_envelope.sv
// iq_envelope: alpha-max-beta-min magnitude estimate of signed I/Q pairs,
// followed by a peak-hold/decay envelope tracker. Four register stages from
// in_valid to valid; one sample accepted per clock, no backpressure.
// Optional feature macro: IQ_ENVELOPE_HOLD_EN builds the HOLD state and its
// sample counter. Without it a new peak goes straight to DECAY and
// HOLD_SAMPLES has no effect.
module iq_envelope #(
  parameter int unsigned HOLD_SAMPLES = 64,
  parameter int unsigned DECAY_SHIFT  = 6
) (
  input  logic         clk,
  input  logic         rst,
  iq_envelope_if.slave bus
);

  // Reject out-of-range configuration at elaboration.
  if (HOLD_SAMPLES > 32'd65535 || DECAY_SHIFT < 32'd1 || DECAY_SHIFT > 32'd15) begin : g_param_check
    $error("iq_envelope: HOLD_SAMPLES must be 0..65535 and DECAY_SHIFT 1..15");
  end

  typedef enum logic [1:0] {
    IDLE,
`ifdef IQ_ENVELOPE_HOLD_EN
    HOLD,
`endif
    DECAY
  } state_t;

  logic        v1, v2, v3;
  logic [15:0] abs_i, abs_q;
  logic [15:0] a1, b1;
  logic [15:0] mx2, mn2;
  logic [16:0] mag_sum;
  logic [16:0] mag3;

  state_t      state, state_n;
  logic [15:0] env, env_n;
  logic [15:0] step;
  logic        peak;
  logic        valid_r;
`ifdef IQ_ENVELOPE_HOLD_EN
  logic [15:0] hold_cnt, hold_n;
`endif

  // Two's-complement magnitude; -32768 maps to 32768 in the unsigned result.
  always_comb begin
    abs_i = bus.in_i[15] ? (~bus.in_i + 16'd1) : bus.in_i;
    abs_q = bus.in_q[15] ? (~bus.in_q + 16'd1) : bus.in_q;
  end

  // Stage 1: register absolute values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      a1 <= '0;
      b1 <= '0;
    end else begin
      v1 <= bus.in_valid;
      a1 <= abs_i;
      b1 <= abs_q;
    end
  end

  // Stage 2: sort into larger and smaller component.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2  <= 1'b0;
      mx2 <= '0;
      mn2 <= '0;
    end else begin
      v2  <= v1;
      mx2 <= (a1 >= b1) ? a1 : b1;
      mn2 <= (a1 >= b1) ? b1 : a1;
    end
  end

  // Magnitude estimate mx + mn/2 - mx/16; peaks at 47104 so 17 bits never wrap.
  always_comb begin
    mag_sum = {1'b0, mx2} + {2'b00, mn2[15:1]} - {5'b00000, mx2[15:4]};
  end

  // Stage 3: register the magnitude.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3   <= 1'b0;
      mag3 <= '0;
    end else begin
      v3   <= v2;
      mag3 <= mag_sum;
    end
  end

  // Envelope next-state: a non-zero sample at or above env restarts the peak;
  // otherwise hold, decay or stay idle. Updates only on a stage-3 sample.
  always_comb begin
    state_n = state;
    env_n   = env;
`ifdef IQ_ENVELOPE_HOLD_EN
    hold_n  = hold_cnt;
`endif
    step = env >> DECAY_SHIFT;
    if (step == '0) step = 16'd1;
    peak = (mag3 != '0) && (mag3 >= {1'b0, env});
    if (v3) begin
      if (peak) begin
        env_n = mag3[15:0];
`ifdef IQ_ENVELOPE_HOLD_EN
        hold_n  = 16'(HOLD_SAMPLES);
        state_n = (HOLD_SAMPLES == 0) ? DECAY : HOLD;
`else
        state_n = DECAY;
`endif
      end else begin
        case (state)
`ifdef IQ_ENVELOPE_HOLD_EN
          HOLD: begin
            hold_n = hold_cnt - 16'd1;
            if (hold_n == '0) state_n = DECAY;
          end
`endif
          DECAY: begin
            env_n = env - step;
            if (env_n == '0) state_n = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // Stage 4: envelope state, which is also the registered amplitude output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      env      <= '0;
      valid_r  <= 1'b0;
`ifdef IQ_ENVELOPE_HOLD_EN
      hold_cnt <= '0;
`endif
    end else begin
      state    <= state_n;
      env      <= env_n;
      valid_r  <= v3;
`ifdef IQ_ENVELOPE_HOLD_EN
      hold_cnt <= hold_n;
`endif
    end
  end

  assign bus.amplitude = env;
  assign bus.valid     = valid_r;

endmodule

// File: tb/tb_iq_envelope.sv
// Testbench for iq_envelope: two instances (hold 4 / shift 4 and hold 0 /
// shift 6) driven with identical samples, each checked against an integer
// envelope model through an expected-output FIFO tagged with its due cycle.
module tb_iq_envelope;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iq_envelope_if bus_a ();
  iq_envelope_if bus_b ();

  iq_envelope #(.HOLD_SAMPLES(4), .DECAY_SHIFT(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  iq_envelope #(.HOLD_SAMPLES(0), .DECAY_SHIFT(6)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

`ifdef IQ_ENVELOPE_HOLD_EN
  localparam int HOLD_A = 4;
`else
  localparam int HOLD_A = 0;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state and expected-output FIFOs.
  int env_m [2];
  int hold_m [2];
  int exp_due [2][16];
  int exp_amp [2][16];
  int head [2];
  int tail [2];
  int strobes [2];
  int last_amp [2];

  function automatic int mag_of(int i, int q);
    int a, b, mx, mn;
    a  = (i < 0) ? -i : i;
    b  = (q < 0) ? -q : q;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    return mx + mn / 2 - mx / 16;
  endfunction

  function automatic int hold_cfg(int k);
    return (k == 0) ? HOLD_A : 0;
  endfunction

  function automatic int shift_cfg(int k);
    return (k == 0) ? 4 : 6;
  endfunction

  task automatic model_step(input int k, input int m);
    int st;
    if (m > 0 && m >= env_m[k]) begin
      env_m[k]  = m;
      hold_m[k] = hold_cfg(k);
    end else if (hold_m[k] > 0) begin
      hold_m[k] = hold_m[k] - 1;
    end else if (env_m[k] > 0) begin
      st = env_m[k] / (1 << shift_cfg(k));
      if (st == 0) st = 1;
      env_m[k] = env_m[k] - st;
    end
  endtask

  task automatic drive(input bit v, input int i, input int q);
    int m;
    bus_a.in_valid = v;  bus_a.in_i = 16'(i);  bus_a.in_q = 16'(q);
    bus_b.in_valid = v;  bus_b.in_i = 16'(i);  bus_b.in_q = 16'(q);
    if (v && !rst) begin
      m = mag_of(i, q);
      for (int k = 0; k < 2; k++) begin
        model_step(k, m);
        exp_due[k][tail[k] % 16] = cyc + 4;
        exp_amp[k][tail[k] % 16] = env_m[k];
        tail[k] = tail[k] + 1;
      end
    end
  endtask

  task automatic idle(input int n);
    drive(1'b0, 0, 0);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int i, input int q);
    drive(1'b1, i, q);
    @(posedge clk); #1;
    drive(1'b0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      env_m[k] = 0;  hold_m[k] = 0;  head[k] = 0;  tail[k] = 0;  last_amp[k] = 0;
    end
    drive(1'b0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Output monitor on the falling edge: every strobe must match the next
  // expected entry at its due cycle; amplitude must hold between strobes.
  logic        mon_vld;
  logic [15:0] mon_amp;
  int          mon_idx;
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      mon_vld = (k == 0) ? bus_a.valid : bus_b.valid;
      mon_amp = (k == 0) ? bus_a.amplitude : bus_b.amplitude;
      if (mon_vld === 1'b1) begin
        strobes[k] = strobes[k] + 1;
        if (head[k] == tail[k]) begin
          checks++;
          assert (mon_vld === 1'b0) else begin
            errors++;
            $error("FAIL spurious_strobe dut=%0d cycle=%0d observed valid=%0b expected valid=0", k, cyc, mon_vld);
          end
        end else begin
          mon_idx = head[k] % 16;
          head[k] = head[k] + 1;
          checks++;
          assert (mon_amp === 16'(exp_amp[k][mon_idx])) else begin
            errors++;
            $error("FAIL amplitude dut=%0d cycle=%0d observed=%0d expected=%0d", k, cyc, mon_amp, exp_amp[k][mon_idx]);
          end
          checks++;
          assert (cyc === exp_due[k][mon_idx]) else begin
            errors++;
            $error("FAIL latency dut=%0d observed cycle=%0d expected cycle=%0d", k, cyc, exp_due[k][mon_idx]);
          end
          last_amp[k] = exp_amp[k][mon_idx];
        end
      end else begin
        checks++;
        assert (mon_amp === 16'(last_amp[k])) else begin
          errors++;
          $error("FAIL amp_hold dut=%0d cycle=%0d observed=%0d expected=%0d", k, cyc, mon_amp, last_amp[k]);
        end
        if (head[k] != tail[k] && exp_due[k][head[k] % 16] <= cyc) begin
          checks++;
          assert (mon_vld === 1'b1) else begin
            errors++;
            $error("FAIL missing_strobe dut=%0d cycle=%0d observed valid=%0b expected valid=1", k, cyc, mon_vld);
          end
          head[k] = head[k] + 1;
        end
      end
    end
  end

  logic signed [15:0] ri, rq;
  int                 sh;

  initial begin
    for (int k = 0; k < 2; k++) begin
      env_m[k] = 0;  hold_m[k] = 0;  head[k] = 0;  tail[k] = 0;
      strobes[k] = 0;  last_amp[k] = 0;
    end

    // Reset held 10 cycles with in_valid toggling; nothing may come out.
    rst = 1'b1;
    drive(1'b0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      drive(c[0], int'($urandom_range(0, 20000)), int'($urandom_range(0, 20000)));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(6);

    // Single sample: 3000/4000 -> 5250 after 4 cycles, nothing else.
    send(3000, 4000);
    idle(10);

    // Extremes, then a tiny sample that starts the decay; run until env is 0.
    do_reset();
    send(-32768, -32768);
    send(0, -1);
    for (int n = 0; n < 800; n++) send(0, 0);
    idle(6);
    checks++;
    assert (bus_a.amplitude === 16'd0) else begin
      errors++;
      $error("FAIL decay_to_zero_a observed=%0d expected=0", bus_a.amplitude);
    end
    checks++;
    assert (bus_b.amplitude === 16'd0) else begin
      errors++;
      $error("FAIL decay_to_zero_b observed=%0d expected=0", bus_b.amplitude);
    end

    // Hold/decay profile from a 5250 step followed by zero samples.
    do_reset();
    send(3000, 4000);
    for (int n = 0; n < 300; n++) send(0, 0);
    idle(6);

    // Ramp: 100 back-to-back samples, then 100 at every 5th cycle.
    do_reset();
    strobes[0] = 0;
    strobes[1] = 0;
    for (int n = 1; n <= 100; n++) send(150 * n, -60 * n);
    for (int n = 101; n <= 200; n++) begin
      send(150 * n, -60 * n);
      idle(4);
    end
    idle(6);
    checks++;
    assert (strobes[0] === 200) else begin
      errors++;
      $error("FAIL strobe_count_a observed=%0d expected=200", strobes[0]);
    end
    checks++;
    assert (strobes[1] === 200) else begin
      errors++;
      $error("FAIL strobe_count_b observed=%0d expected=200", strobes[1]);
    end

    // Random samples of varying scale and spacing.
    for (int n = 0; n < 200; n++) begin
      ri = 16'($urandom);
      rq = 16'($urandom);
      sh = 4 * int'($urandom_range(0, 3));
      send(int'(ri) >>> sh, int'(rq) >>> sh);
      idle(int'($urandom_range(0, 3)));
    end
    idle(6);

    // Reset with three samples in flight; they must vanish and the next
    // sample must start from an empty envelope.
    send(20000, 1000);
    send(25000, -3000);
    send(-30000, 500);
    do_reset();
    idle(8);
    send(30, 40);
    idle(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
